// File: rtl/ifetch_line_prefetch.sv
// Two-line instruction buffer with sequential prefetch between the local store and fetch.
// Ports: clk/reset; fetch side if_req/if_pc/if_flush/inv_all -> if_valid/if_instr0/if_instr1;
// LS side ls_req/ls_addr/ls_gnt/ls_rvalid/ls_rdata (quadword beats, lowest word in bits 0:31).
module ifetch_line_prefetch #(
    parameter int PC_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [PC_W-1:0] if_pc,
    input  logic            if_flush,
    input  logic            inv_all,
    output logic            if_valid,
    output logic [0:31]     if_instr0,
    output logic [0:31]     if_instr1,
    output logic            ls_req,
    output logic [PC_W-3:0] ls_addr,
    input  logic            ls_gnt,
    input  logic            ls_rvalid,
    input  logic [0:127]    ls_rdata
);
    localparam int TW = PC_W - 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [31:0]   mem [2][16];
    logic [TW-1:0] tag [2];
    logic [1:0]    vld;
    logic          lru;

    logic [1:0]    beat;
    logic [1:0]    rbeat;
    logic [2:0]    outst;
    logic          fill_buf;
    logic          fill_pf;
    logic [TW-1:0] fill_tag;
    logic          pulse;

    logic [TW-1:0] pc_tag;
    logic [3:0]    pc_word;
    logic          filling;
    logic [1:0]    hit_b;
    logic          hit;
    logic          hit_idx;
    logic          serve;
    logic          miss;
    logic          mru;
    logic [TW-1:0] pf_tag;
    logic          pf_present;
    logic          pf_go;
    logic          gnt_acc;
    logic          ret_acc;
    logic [2:0]    out_nxt;
    logic          last_ret;
    logic          kill;
    logic          redirect;
    logic          start_dem;
    logic          start_pf;
    logic          complete;

    assign pc_tag  = if_pc[PC_W-1:4];
    assign pc_word = if_pc[3:0];
    assign filling = (state == REQ) || (state == WAIT);

    // The buffer under fill has its valid bit cleared, but exclude it
    // explicitly so a stale tag can never alias.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            hit_b[i] = vld[i] && (tag[i] == pc_tag)
                && !(filling && (fill_buf == 1'(i)));
        end
    end

    assign hit     = |hit_b;
    assign hit_idx = hit_b[1];
    assign serve   = if_req && !if_flush && hit;
    assign miss    = if_req && !if_flush && !hit;

    // Next sequential line after the most recently used one; the
    // tag width makes the last line wrap to line 0.
    assign mru        = ~lru;
    assign pf_tag     = tag[mru] + 1'b1;
    assign pf_present = (vld[0] && (tag[0] == pf_tag))
                     || (vld[1] && (tag[1] == pf_tag));
    assign pf_go      = !if_req && !if_flush && !inv_all
                     && vld[mru] && !pf_present;

    // Returns with nothing outstanding belong to a fill abandoned by
    // reset and are dropped.
    assign gnt_acc  = (state == REQ) && ls_gnt;
    assign ret_acc  = (state != IDLE) && ls_rvalid && (outst != 3'd0);
    assign out_nxt  = outst + {2'b00, gnt_acc} - {2'b00, ret_acc};
    assign last_ret = filling && ret_acc && (rbeat == 2'd3);

    assign kill     = if_flush || inv_all;
    assign redirect = miss && (pc_tag != fill_tag);

    always_comb begin
        state_nxt = state;
        start_dem = 1'b0;
        start_pf  = 1'b0;
        complete  = 1'b0;
        unique case (state)
            IDLE: begin
                if (miss) begin
                    start_dem = 1'b1;
                    state_nxt = REQ;
                end else if (pf_go) begin
                    start_pf  = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ, WAIT: begin
                if (kill) begin
                    state_nxt = (out_nxt != 3'd0) ? DRAIN : IDLE;
                end else if (last_ret) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end else if (redirect) begin
                    state_nxt = (out_nxt != 3'd0) ? DRAIN : IDLE;
                end else if ((state == REQ) && gnt_acc
                             && (beat == 2'd3)) begin
                    state_nxt = WAIT;
                end
            end
            DRAIN: begin
                if (out_nxt == 3'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            vld       <= 2'b00;
            tag[0]    <= '0;
            tag[1]    <= '0;
            lru       <= 1'b0;
            beat      <= 2'd0;
            rbeat     <= 2'd0;
            outst     <= 3'd0;
            fill_buf  <= 1'b0;
            fill_pf   <= 1'b0;
            fill_tag  <= '0;
            pulse     <= 1'b0;
            if_instr0 <= '0;
            if_instr1 <= '0;
        end else begin
            state <= state_nxt;
            pulse <= serve;
            outst <= out_nxt;

            if (serve) begin
                if_instr0 <= mem[hit_idx][pc_word];
                if_instr1 <= mem[hit_idx][pc_word + 4'd1];
                lru       <= ~hit_idx;
            end

            if (start_dem || start_pf) begin
                fill_buf   <= lru;
                fill_tag   <= start_dem ? pc_tag : pf_tag;
                fill_pf    <= start_pf;
                beat       <= 2'd0;
                rbeat      <= 2'd0;
                vld[lru]   <= 1'b0;
            end

            if (gnt_acc) begin
                beat <= beat + 2'd1;
            end

            if (filling && ret_acc) begin
                for (int k = 0; k < 4; k++) begin
                    mem[fill_buf][{rbeat, 2'(k)}] <= ls_rdata[32*k +: 32];
                end
                rbeat <= rbeat + 2'd1;
            end

            // A completed prefetch leaves LRU alone so the demand line
            // it follows is not chosen as the next victim.
            if (complete) begin
                vld[fill_buf] <= 1'b1;
                tag[fill_buf] <= fill_tag;
                if (!fill_pf) begin
                    lru <= ~fill_buf;
                end
            end

            if (inv_all) begin
                vld <= 2'b00;
            end
        end
    end

    assign if_valid = pulse && !if_flush;
    assign ls_req   = (state == REQ);
    assign ls_addr  = ls_req ? {fill_tag, beat} : '0;

endmodule

// File: tb/tb_ifetch_line_prefetch.sv
// Directed bench for ifetch_line_prefetch with a fixed-latency LS model.
// Ports: drives all DUT inputs, observes fetch and LS outputs on the falling edge.
module tb_ifetch_line_prefetch;
    localparam int PC_W = 16;
    localparam int LAT  = 2;

    logic            clk      = 1'b0;
    logic            reset    = 1'b1;
    logic            if_req   = 1'b0;
    logic [PC_W-1:0] if_pc    = '0;
    logic            if_flush = 1'b0;
    logic            inv_all  = 1'b0;
    logic            if_valid;
    logic [0:31]     if_instr0;
    logic [0:31]     if_instr1;
    logic            ls_req;
    logic [PC_W-3:0] ls_addr;
    logic            ls_gnt;
    logic            ls_rvalid = 1'b0;
    logic [0:127]    ls_rdata  = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [PC_W-3:0] gaddr[$];
    int              gcyc[$];

    typedef struct {
        int              due;
        logic [PC_W-3:0] qa;
    } ret_t;
    ret_t rq[$];

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [31:0]     w0;
        logic [31:0]     w1;
    } vec_t;

    ifetch_line_prefetch #(.PC_W(PC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_pc     (if_pc),
        .if_flush  (if_flush),
        .inv_all   (inv_all),
        .if_valid  (if_valid),
        .if_instr0 (if_instr0),
        .if_instr1 (if_instr1),
        .ls_req    (ls_req),
        .ls_addr   (ls_addr),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata)
    );

    always #5 clk = ~clk;

    assign ls_gnt = ls_req;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word_of(input logic [PC_W-1:0] w);
        return {w ^ 16'hA5C3, w};
    endfunction

    function automatic logic [0:127] qword(input logic [PC_W-3:0] qa);
        logic [0:127] q;
        q = '0;
        for (int k = 0; k < 4; k++) begin
            q[32*k +: 32] = word_of({qa, 2'(k)});
        end
        return q;
    endfunction

    // LS model: grant every request, return data LAT cycles later.
    always @(negedge clk) begin
        ls_rvalid = 1'b0;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            ls_rvalid = 1'b1;
            ls_rdata  = qword(rq[0].qa);
            void'(rq.pop_front());
        end
        if (ls_req && ls_gnt) begin
            rq.push_back('{cyc + LAT, ls_addr});
            gaddr.push_back(ls_addr);
            gcyc.push_back(cyc);
        end
    end

    function automatic logic [PC_W-3:0] gat(input int i);
        return (i < gaddr.size()) ? gaddr[i] : '1;
    endfunction

    function automatic int gct(input int i);
        return (i < gcyc.size()) ? gcyc[i] : -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        if_req   = 1'b0;
        if_flush = 1'b0;
        inv_all  = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        gaddr.delete();
        gcyc.delete();
    endtask

    task automatic fetch(input logic [PC_W-1:0] pc, input int maxc,
                         output int lat, output logic [31:0] i0,
                         output logic [31:0] i1);
        if_pc  = pc;
        if_req = 1'b1;
        lat    = -1;
        i0     = '0;
        i1     = '0;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            if (if_valid) begin
                lat = c;
                i0  = if_instr0;
                i1  = if_instr1;
                break;
            end
        end
        if_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tab[16];
        int          n;
        int          m;
        int          lat;
        logic [31:0] i0;
        logic [31:0] i1;

        for (int i = 0; i < 16; i++) begin
            tab[i].pc = 16'(2 * i);
            tab[i].w0 = word_of(16'(2 * i));
            tab[i].w1 = word_of(16'(2 * i + 1));
        end

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(if_valid), 0);
        chk("rst_i0", 64'(if_instr0), 0);
        chk("rst_i1", 64'(if_instr1), 0);
        chk("rst_ls_req", 64'(ls_req), 0);
        chk("rst_ls_addr", 64'(ls_addr), 0);
        reset = 1'b0;
        gaddr.delete();
        gcyc.delete();
        @(negedge clk);

        // Cold miss then prefetch of line 1
        n = cyc;
        fetch(16'h0000, 20, lat, i0, i1);
        chk("cold_lat", 64'(lat), 8);
        chk("cold_i0", 64'(i0), 64'(word_of(16'h0000)));
        chk("cold_i1", 64'(i1), 64'(word_of(16'h0001)));
        for (int i = 0; i < 4; i++) begin
            chk("cold_addr", 64'(gat(i)), 64'(i));
            chk("cold_cyc", 64'(gct(i)), 64'(n + 1 + i));
        end
        repeat (14) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("pf_addr", 64'(gat(4 + i)), 64'(4 + i));
        end
        chk("pf_start", 64'(gct(4)), 64'(n + 9));
        chk("pf_count", 64'(gaddr.size()), 8);

        // Back-to-back hit stream over both lines
        gaddr.delete();
        gcyc.delete();
        for (int i = 0; i < 16; i++) begin
            if_pc  = tab[i].pc;
            if_req = 1'b1;
            @(negedge clk);
            chk($sformatf("hit_valid_%0h", tab[i].pc), 64'(if_valid), 1);
            chk($sformatf("hit_i0_%0h", tab[i].pc), 64'(if_instr0),
                64'(tab[i].w0));
            chk($sformatf("hit_i1_%0h", tab[i].pc), 64'(if_instr1),
                64'(tab[i].w1));
        end
        if_req = 1'b0;
        chk("hit_no_ls", 64'(gaddr.size()), 0);
        repeat (15) @(negedge clk);

        // Wrap of the prefetch tag
        do_reset();
        fetch(16'hFFF0, 20, lat, i0, i1);
        chk("wrap_lat", 64'(lat), 8);
        chk("wrap_i0", 64'(i0), 64'(word_of(16'hFFF0)));
        chk("wrap_i1", 64'(i1), 64'(word_of(16'hFFF1)));
        chk("wrap_a0", 64'(gat(0)), 64'h3FFC);
        chk("wrap_a3", 64'(gat(3)), 64'h3FFF);
        repeat (14) @(negedge clk);
        chk("wrap_pf_a0", 64'(gat(4)), 64'h0000);
        chk("wrap_pf_a3", 64'(gat(7)), 64'h0003);
        chk("wrap_count", 64'(gaddr.size()), 8);

        // Flush after the second grant
        do_reset();
        if_pc  = 16'h0100;
        if_req = 1'b1;
        repeat (2) @(negedge clk);
        if_flush = 1'b1;
        if_req   = 1'b0;
        @(negedge clk);
        if_flush = 1'b0;
        chk("flush_valid_next", 64'(if_valid), 0);
        m = 0;
        repeat (10) begin
            @(negedge clk);
            if (if_valid) m++;
        end
        chk("flush_no_valid", 64'(m), 0);
        chk("flush_grants", 64'(gaddr.size()), 2);
        fetch(16'h0100, 20, lat, i0, i1);
        chk("refetch_lat", 64'(lat), 8);
        chk("refetch_i0", 64'(i0), 64'(word_of(16'h0100)));
        chk("refetch_i1", 64'(i1), 64'(word_of(16'h0101)));
        chk("refetch_count", 64'(gaddr.size()), 6);
        chk("refetch_a0", 64'(gat(2)), 64'h0040);
        chk("refetch_a3", 64'(gat(5)), 64'h0043);
        repeat (15) @(negedge clk);

        // Demand miss to another line during a prefetch
        do_reset();
        fetch(16'h0000, 20, lat, i0, i1);
        chk("dvp_cold_lat", 64'(lat), 8);
        repeat (2) @(negedge clk);
        m = cyc;
        fetch(16'h0400, 30, lat, i0, i1);
        chk("dvp_lat", 64'(lat), 11);
        chk("dvp_i0", 64'(i0), 64'(word_of(16'h0400)));
        chk("dvp_i1", 64'(i1), 64'(word_of(16'h0401)));
        chk("dvp_pf_a0", 64'(gat(4)), 64'h0004);
        chk("dvp_pf_a1", 64'(gat(5)), 64'h0005);
        chk("dvp_dem_a0", 64'(gat(6)), 64'h0100);
        chk("dvp_dem_a3", 64'(gat(9)), 64'h0103);
        chk("dvp_dem_cyc", 64'(gct(6)), 64'(m + 4));
        chk("dvp_count", 64'(gaddr.size()), 10);
        repeat (15) @(negedge clk);

        // inv_all on the final return of a fill
        do_reset();
        n = cyc;
        if_pc  = 16'h0200;
        if_req = 1'b1;
        repeat (6) @(negedge clk);
        inv_all = 1'b1;
        @(negedge clk);
        inv_all = 1'b0;
        chk("inv_valid_7", 64'(if_valid), 0);
        @(negedge clk);
        chk("inv_valid_8", 64'(if_valid), 0);
        chk("inv_refetch_req", 64'(ls_req), 1);
        lat = -1;
        for (int c = 9; c <= 30; c++) begin
            @(negedge clk);
            if (if_valid) begin
                lat = c;
                i0  = if_instr0;
                i1  = if_instr1;
                break;
            end
        end
        if_req = 1'b0;
        chk("inv_lat", 64'(lat), 15);
        chk("inv_i0", 64'(i0), 64'(word_of(16'h0200)));
        chk("inv_i1", 64'(i1), 64'(word_of(16'h0201)));
        chk("inv_count", 64'(gaddr.size()), 8);
        chk("inv_cyc", 64'(gct(4)), 64'(n + 8));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
